// File: rtl/apb_fifo_responder.sv
// apb_fifo_responder: APB3 completer fronting a 32-bit mailbox FIFO.
//   Register map (PADDR[3:2]): 0x0 CTRL, 0x4 STATUS, 0x8 TXD (push), 0xC RXD (pop).
//   Every transfer takes exactly one wait state. The read data and the error flag are
//   captured on entry to the access cycle. Side effects commit at the end of the access
//   cycle, and only if PSEL/PENABLE are still held.
// Ports:
//   clk, reset          single rising-edge clock, synchronous active-high reset
//   PADDR/PSEL/PENABLE  APB address and control
//   PWRITE/PWDATA       APB write direction and data
//   PRDATA/PREADY       read data (valid with PREADY) and transfer complete
//   PSLVERR             error response (valid with PREADY)
//   irq                 CTRL.irq_en & FIFO not empty
module apb_fifo_responder #(
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned ADDR_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] PADDR,
  input  logic              PSEL,
  input  logic              PENABLE,
  input  logic              PWRITE,
  input  logic [31:0]       PWDATA,
  output logic [31:0]       PRDATA,
  output logic              PREADY,
  output logic              PSLVERR,
  output logic              irq
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] FullCnt = CntW'(DEPTH);

  localparam logic [1:0] RegCtrl   = 2'd0;
  localparam logic [1:0] RegStatus = 2'd1;
  localparam logic [1:0] RegTxd    = 2'd2;
  localparam logic [1:0] RegRxd    = 2'd3;

  typedef enum logic [0:0] {StIdle, StAccess} state_e;

  state_e            r_state, w_state_next;
  logic [31:0]       r_prdata, r_wdata, w_rdata;
  logic              r_err, w_err;
  logic [1:0]        r_reg;
  logic              r_write;
  logic [31:0]       r_mem [DEPTH];
  logic [PtrW-1:0]   r_wr_ptr, r_rd_ptr;
  logic [CntW-1:0]   r_count;
  logic              r_irq_en;
  logic              w_empty, w_full;
  logic              w_start, w_commit, w_push, w_pop, w_ctrl_wr, w_flush;
  logic [1:0]        w_unused_paddr;

  // Byte-lane bits are not decoded.
  assign w_unused_paddr = PADDR[1:0];

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == FullCnt);

  assign w_start  = (r_state == StIdle) & PSEL & PENABLE;
  // Commit only if the master still holds the transfer; reset abandons it.
  assign w_commit = (r_state == StAccess) & PSEL & PENABLE & ~r_err & ~reset;
  assign w_push    = w_commit &  r_write & (r_reg == RegTxd);
  assign w_pop     = w_commit & ~r_write & (r_reg == RegRxd);
  assign w_ctrl_wr = w_commit &  r_write & (r_reg == RegCtrl);
  assign w_flush   = w_ctrl_wr & r_wdata[1];

  // Decode the live APB request; captured only when entering the access cycle.
  always_comb begin
    w_rdata = '0;
    w_err   = 1'b0;
    case (PADDR[3:2])
      RegCtrl: begin
        if (!PWRITE) w_rdata = {31'h0, r_irq_en};
      end
      RegStatus: begin
        if (PWRITE) w_err = 1'b1;
        else        w_rdata = {16'h0, 8'(r_count), 6'h0, w_full, w_empty};
      end
      RegTxd: begin
        w_err = PWRITE ? w_full : 1'b1;
      end
      RegRxd: begin
        if (!PWRITE) begin
          if (w_empty) w_err = 1'b1;
          else         w_rdata = r_mem[r_rd_ptr];
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    w_state_next = r_state;
    PREADY       = 1'b0;
    PSLVERR      = 1'b0;
    PRDATA       = r_prdata;
    unique case (r_state)
      StIdle: begin
        if (w_start) w_state_next = StAccess;
      end
      StAccess: begin
        PREADY       = 1'b1;
        PSLVERR      = r_err;
        w_state_next = StIdle;
      end
      default: w_state_next = StIdle;
    endcase
  end

  assign irq = r_irq_en & ~w_empty;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= StIdle;
      r_prdata <= '0;
      r_err    <= 1'b0;
      r_reg    <= '0;
      r_write  <= 1'b0;
      r_wdata  <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_irq_en <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (w_start) begin
        r_prdata <= w_rdata;
        r_err    <= w_err;
        r_reg    <= PADDR[3:2];
        r_write  <= PWRITE;
        r_wdata  <= PWDATA;
      end
      if (w_ctrl_wr) r_irq_en <= r_wdata[0];
      if (w_flush) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_count  <= '0;
      end else if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PtrW'(1);
        r_count  <= r_count + CntW'(1);
      end else if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PtrW'(1);
        r_count  <= r_count - CntW'(1);
      end
    end
  end

  // Storage needs no reset; pointers and count define its validity.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= r_wdata;
  end

endmodule

// File: tb/tb_apb_fifo_responder.sv
// Self-checking bench for apb_fifo_responder: directed scenarios plus randomized
// transfers, each compared against a queue-based model of the mailbox.
module tb_apb_fifo_responder;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  PADDR;
  logic        PSEL, PENABLE, PWRITE;
  logic [31:0] PWDATA, PRDATA;
  logic        PREADY, PSLVERR, irq;

  apb_fifo_responder #(.DEPTH(DEPTH), .ADDR_W(4)) dut (
    .clk     (clk),
    .reset   (reset),
    .PADDR   (PADDR),
    .PSEL    (PSEL),
    .PENABLE (PENABLE),
    .PWRITE  (PWRITE),
    .PWDATA  (PWDATA),
    .PRDATA  (PRDATA),
    .PREADY  (PREADY),
    .PSLVERR (PSLVERR),
    .irq     (irq)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Model state.
  logic [31:0] m_q [$];
  logic        m_irq_en = 1'b0;

  logic [31:0] last_rdata;
  logic        last_err;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] m_status();
    int n = m_q.size();
    return {16'h0, 8'(n), 6'h0, n == DEPTH, n == 0};
  endfunction

  // One APB transfer; entered and left at posedge+1. Abort drops PSEL during ACCESS.
  task automatic xfer(input logic [3:0] addr, input logic wr, input logic [31:0] wdata,
                      input bit abort, output logic [31:0] rdata, output logic err,
                      output int waits);
    bit done = 0;
    PADDR = addr; PWRITE = wr; PWDATA = wdata; PSEL = 1'b1; PENABLE = 1'b0;
    @(posedge clk); #1;
    PENABLE = 1'b1;
    waits = 0; rdata = '0; err = 1'b0;
    for (int i = 0; i < 6 && !done; i++) begin
      @(negedge clk);
      if (PREADY) begin
        rdata = PRDATA;
        err   = PSLVERR;
        done  = 1;
        if (abort) begin PSEL = 1'b0; PENABLE = 1'b0; end
      end else begin
        waits++;
      end
      @(posedge clk); #1;
    end
    if (!done) check("ready_timeout", 32'd0, 32'd1);
    PSEL = 1'b0; PENABLE = 1'b0;
  endtask

  task automatic op(input logic [3:0] addr, input logic wr, input logic [31:0] wdata,
                    input bit abort);
    logic [31:0] exp_data = '0;
    logic        exp_err  = 1'b0;
    int          n = m_q.size();
    int          waits;
    case (addr[3:2])
      2'd0: if (!wr) exp_data = {31'h0, m_irq_en};
      2'd1: if (wr) exp_err = 1'b1; else exp_data = m_status();
      2'd2: exp_err = wr ? (n == DEPTH) : 1'b1;
      2'd3: if (!wr) begin
              if (n == 0) exp_err = 1'b1;
              else        exp_data = m_q[0];
            end
      default: ;
    endcase
    xfer(addr, wr, wdata, abort, last_rdata, last_err, waits);
    check("wait_states", waits, 1);
    check("pslverr", {31'h0, last_err}, {31'h0, exp_err});
    if (!wr) check("prdata", last_rdata, exp_data);
    if (!abort && !exp_err) begin
      case (addr[3:2])
        2'd0: if (wr) begin
                m_irq_en = wdata[0];
                if (wdata[1]) m_q.delete();
              end
        2'd2: m_q.push_back(wdata);
        2'd3: if (!wr) void'(m_q.pop_front());
        default: ;
      endcase
    end
    check("irq", {31'h0, irq}, {31'h0, m_irq_en && m_q.size() != 0});
  endtask

  initial begin
    reset = 1'b1; PADDR = '0; PSEL = 0; PENABLE = 0; PWRITE = 0; PWDATA = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_pready", {31'h0, PREADY}, 32'h0);
    check("rst_pslverr", {31'h0, PSLVERR}, 32'h0);
    check("rst_prdata", PRDATA, 32'h0);
    check("rst_irq", {31'h0, irq}, 32'h0);
    @(posedge clk); #1;
    reset = 1'b0;

    // Reset mid-transfer abandons it.
    op(4'h0, 1, 32'h1, 0);
    op(4'h8, 1, 32'h55, 0);
    PADDR = 4'h8; PWRITE = 1; PWDATA = 32'h66; PSEL = 1; PENABLE = 0;
    @(posedge clk); #1; PENABLE = 1;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    PSEL = 0; PENABLE = 0;
    @(negedge clk);
    check("midrst_pready", {31'h0, PREADY}, 32'h0);
    check("midrst_irq", {31'h0, irq}, 32'h0);
    @(posedge clk); #1;
    reset = 1'b0;
    m_q.delete(); m_irq_en = 1'b0;
    op(4'h4, 0, 0, 0);
    check("midrst_status", last_rdata, 32'h1);

    // Timing: one wait state, then idle.
    op(4'h8, 1, 32'hDEADBEEF, 0);
    @(negedge clk);
    check("idle_after_access", {31'h0, PREADY}, 32'h0);
    @(posedge clk); #1;
    op(4'h4, 0, 0, 0);
    check("status_one", last_rdata, 32'h0000_0100);
    op(4'hC, 0, 0, 0);
    check("pop_deadbeef", last_rdata, 32'hDEADBEEF);

    // Ordering and pointer wrap.
    for (int i = 1; i <= 8; i++) op(4'h8, 1, i, 0);
    op(4'h4, 0, 0, 0);
    check("status_full", last_rdata, 32'h0000_0802);
    for (int i = 1; i <= 3; i++) begin
      op(4'hC, 0, 0, 0);
      check("pop_early", last_rdata, i);
    end
    for (int i = 9; i <= 11; i++) op(4'h8, 1, i, 0);
    for (int i = 4; i <= 11; i++) begin
      op(4'hC, 0, 0, 0);
      check("pop_wrap", last_rdata, i);
    end
    op(4'h4, 0, 0, 0);
    check("status_empty", last_rdata, 32'h1);

    // Errors.
    for (int i = 0; i < 8; i++) op(4'h8, 1, 32'hA0 + i, 0);
    op(4'h8, 1, 32'hBAD, 0);
    check("push_full_err", {31'h0, last_err}, 32'h1);
    op(4'h4, 0, 0, 0);
    check("status_still_full", last_rdata, 32'h0000_0802);
    op(4'h0, 1, 32'h2, 0);
    op(4'hC, 0, 0, 0);
    check("pop_empty_err", {31'h0, last_err}, 32'h1);
    check("pop_empty_data", last_rdata, 32'h0);
    op(4'h4, 1, 32'hFFFF, 0);
    check("wr_status_err", {31'h0, last_err}, 32'h1);
    op(4'h8, 0, 0, 0);
    check("rd_txd_err", {31'h0, last_err}, 32'h1);

    // irq and flush.
    op(4'h0, 1, 32'h1, 0);
    op(4'h8, 1, 32'h77, 0);
    check("irq_set", {31'h0, irq}, 32'h1);
    op(4'h0, 1, 32'h3, 0);
    check("irq_flushed", {31'h0, irq}, 32'h0);
    op(4'h4, 0, 0, 0);
    check("flush_status", last_rdata, 32'h1);
    op(4'h0, 0, 0, 0);
    check("ctrl_read", last_rdata, 32'h1);

    // Abort during ACCESS: no push.
    op(4'h8, 1, 32'h1234, 1);
    @(negedge clk);
    check("abort_idle", {31'h0, PREADY}, 32'h0);
    @(posedge clk); #1;
    op(4'h4, 0, 0, 0);
    check("abort_status", last_rdata, 32'h1);

    // Randomized traffic.
    for (int k = 0; k < 400; k++) begin
      int unsigned sel = $urandom_range(0, 9);
      logic [3:0]  a   = 4'($urandom_range(0, 15));
      logic        w   = 1'($urandom_range(0, 1));
      logic [31:0] d   = $urandom;
      bit          ab  = ($urandom_range(0, 9) == 0);
      if (sel <= 3)      begin a = {2'd2, a[1:0]}; w = 1'b1; end
      else if (sel <= 6) begin a = {2'd3, a[1:0]}; w = 1'b0; end
      else if (sel == 7) begin a = {2'd0, a[1:0]}; if (w && d[1]) d[1] = ($urandom_range(0, 3) == 0); end
      else if (sel == 8) a = {2'd1, a[1:0]};
      else if (a[3:2] == 2'd0 && w) d[1] = ($urandom_range(0, 3) == 0);
      op(a, w, d, ab);
    end
    op(4'h4, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
